// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus for the fetch stage.
// One read outstanding at a time; address held until the response.
interface fetch_unit_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_VALID;

  modport master (
    output IMEM_REQ, IMEM_ADDR,
    input  IMEM_RDATA, IMEM_VALID
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR,
    output IMEM_RDATA, IMEM_VALID
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-deep request FSM, skid buffer
// and the IF/ID pipeline register.
module fetch_unit (
  input  logic         CLK,
  input  logic         RST,
  input  logic [1:0]   PC_SOURCE,
  input  logic [31:0]  MUX_JALR,
  input  logic [31:0]  MUX_BRANCH,
  input  logic [31:0]  MUX_JAL,
  input  logic         STALL,
  fetch_unit_if.master imem,
  output logic [31:0]  FETCH_REG_OUT,
  output logic [31:0]  FETCH_REG_PC,
  output logic [31:0]  FETCH_REG_PC_4,
  output logic         FETCH_VALID
);
  typedef enum logic [1:0] {
    S_REQ, S_WAIT, S_HOLD
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] irpc_q, irpc_d;
  logic [31:0] irpc4_q, irpc4_d;
  logic [31:0] skir_q, skir_d;
  logic [31:0] skpc_q, skpc_d;
  logic        vld_q, vld_d;
  logic        drop_q, drop_d;
  logic        redir, resp;
  logic [31:0] sel, tgt;

  assign redir = PC_SOURCE != 2'd0;
  assign resp  = (state_q == S_WAIT) && imem.IMEM_VALID;

  always_comb begin
    sel = MUX_JAL;
    unique case (1'b1)
      PC_SOURCE == 2'd1: sel = MUX_JALR;
      PC_SOURCE == 2'd2: sel = MUX_BRANCH;
      default:           sel = MUX_JAL;
    endcase
  end

  assign tgt = sel & 32'hFFFF_FFFC;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_REQ;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:  if (!redir) state_d = S_WAIT;
      S_WAIT: begin
        if (imem.IMEM_VALID)
          state_d = (redir || drop_q || !STALL)
                    ? S_REQ : S_HOLD;
      end
      S_HOLD: if (redir || !STALL) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    imem.IMEM_REQ  = RST && (state_q == S_REQ) && !redir;
    imem.IMEM_ADDR = pc_q;
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    irpc_d  = irpc_q;
    irpc4_d = irpc4_q;
    vld_d   = vld_q;
    skir_d  = skir_q;
    skpc_d  = skpc_q;
    drop_d  = drop_q;
    if (redir) begin
      pc_d   = tgt;
      ir_d   = NOP;
      vld_d  = 1'b0;
      skir_d = '0;
      skpc_d = '0;
      // an unanswered request must not land after the jump
      drop_d = (state_q == S_WAIT) && !imem.IMEM_VALID;
    end else if (resp && drop_q) begin
      drop_d = 1'b0;
      if (!STALL) begin
        ir_d  = NOP;
        vld_d = 1'b0;
      end
    end else if (resp && !STALL) begin
      ir_d    = imem.IMEM_RDATA;
      irpc_d  = pc_q;
      irpc4_d = pc_q + 32'd4;
      vld_d   = 1'b1;
      pc_d    = pc_q + 32'd4;
    end else if (resp) begin
      skir_d = imem.IMEM_RDATA;
      skpc_d = pc_q;
      pc_d   = pc_q + 32'd4;
    end else if (state_q == S_HOLD && !STALL) begin
      ir_d    = skir_q;
      irpc_d  = skpc_q;
      irpc4_d = skpc_q + 32'd4;
      vld_d   = 1'b1;
    end else if (!STALL) begin
      ir_d  = NOP;
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q    <= '0;
      ir_q    <= NOP;
      irpc_q  <= '0;
      irpc4_q <= '0;
      vld_q   <= 1'b0;
      skir_q  <= '0;
      skpc_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      irpc_q  <= irpc_d;
      irpc4_q <= irpc4_d;
      vld_q   <= vld_d;
      skir_q  <= skir_d;
      skpc_q  <= skpc_d;
      drop_q  <= drop_d;
    end
  end

  assign FETCH_REG_OUT  = ir_q;
  assign FETCH_REG_PC   = irpc_q;
  assign FETCH_REG_PC_4 = irpc4_q;
  assign FETCH_VALID    = vld_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations,
// then random stall/redirect/latency against a transaction-level model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [1:0]  PC_SOURCE = 2'd0;
  logic [31:0] MUX_JALR = '0;
  logic [31:0] MUX_BRANCH = '0;
  logic [31:0] MUX_JAL = '0;
  logic        STALL = 1'b0;
  logic [31:0] FETCH_REG_OUT, FETCH_REG_PC, FETCH_REG_PC_4;
  logic        FETCH_VALID;

  fetch_unit_if bus();

  fetch_unit dut (
    .CLK            (CLK),
    .RST            (RST),
    .PC_SOURCE      (PC_SOURCE),
    .MUX_JALR       (MUX_JALR),
    .MUX_BRANCH     (MUX_BRANCH),
    .MUX_JAL        (MUX_JAL),
    .STALL          (STALL),
    .imem           (bus),
    .FETCH_REG_OUT  (FETCH_REG_OUT),
    .FETCH_REG_PC   (FETCH_REG_PC),
    .FETCH_REG_PC_4 (FETCH_REG_PC_4),
    .FETCH_VALID    (FETCH_VALID)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // transaction-level model
  logic [31:0] m_pc;
  bit          m_inflight;
  bit          m_stale;
  logic [63:0] m_buf[$];
  logic [31:0] m_out, m_fpc, m_fpc4;
  logic        m_fv;
  logic        g_req;
  logic [31:0] g_addr;

  // memory responder for the random phase
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = '0;
    m_inflight = 0;
    m_stale = 0;
    m_buf.delete();
    m_out = NOP;
    m_fpc = '0;
    m_fpc4 = '0;
    m_fv = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, FETCH_VALID}, 32'd0);
    chk({tag, "_out"}, FETCH_REG_OUT, NOP);
    chk({tag, "_pc"}, FETCH_REG_PC, 32'd0);
    chk({tag, "_pc4"}, FETCH_REG_PC_4, 32'd0);
    chk({tag, "_req"}, {31'b0, bus.IMEM_REQ}, 32'd0);
    chk({tag, "_addr"}, bus.IMEM_ADDR, 32'd0);
  endtask

  // one clock: drive at negedge, check request, advance model, check IF/ID
  task automatic step(input logic [1:0] src, input logic st,
                      input logic vld, input logic [31:0] rd);
    logic [31:0] sel;
    logic [31:0] tgt;
    logic [63:0] e;
    PC_SOURCE = src;
    STALL = st;
    bus.IMEM_VALID = vld;
    bus.IMEM_RDATA = rd;
    #1;
    g_req = !m_inflight && m_buf.size() == 0 && src == 2'd0;
    g_addr = m_pc;
    chk("imem_req", {31'b0, bus.IMEM_REQ}, {31'b0, g_req});
    chk("imem_addr", bus.IMEM_ADDR, m_pc);
    case (src)
      2'd1:    sel = MUX_JALR;
      2'd2:    sel = MUX_BRANCH;
      default: sel = MUX_JAL;
    endcase
    tgt = {sel[31:2], 2'b00};
    if (src != 2'd0) begin
      if (m_inflight && !vld) m_stale = 1;
      else begin
        m_inflight = 0;
        m_stale = 0;
      end
      m_buf.delete();
      m_pc = tgt;
      m_fv = 1'b0;
      m_out = NOP;
    end else begin
      if (m_inflight && vld) begin
        m_inflight = 0;
        if (m_stale) m_stale = 0;
        else begin
          m_buf.push_back({rd, m_pc});
          m_pc = m_pc + 32'd4;
        end
      end else if (g_req) m_inflight = 1;
      if (!st) begin
        if (m_buf.size() != 0) begin
          e = m_buf.pop_front();
          m_out = e[63:32];
          m_fpc = e[31:0];
          m_fpc4 = e[31:0] + 32'd4;
          m_fv = 1'b1;
        end else begin
          m_out = NOP;
          m_fv = 1'b0;
        end
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    chk("fetch_valid", {31'b0, FETCH_VALID}, {31'b0, m_fv});
    chk("fetch_out", FETCH_REG_OUT, m_out);
    chk("fetch_pc", FETCH_REG_PC, m_fpc);
    chk("fetch_pc4", FETCH_REG_PC_4, m_fpc4);
  endtask

  logic [1:0] r_src;
  logic       r_st, r_vld;

  initial begin
    bus.IMEM_VALID = 1'b0;
    bus.IMEM_RDATA = '0;
    m_reset();
    repeat (2) @(negedge CLK);
    chk_reset_outputs("rst");
    RST = 1'b1;
    #1;
    chk("first_req", {31'b0, bus.IMEM_REQ}, 32'd1);
    chk("first_addr", bus.IMEM_ADDR, 32'h0);

    // 1-cycle latency fetch
    step(2'd0, 1'b0, 1'b0, '0);
    step(2'd0, 1'b0, 1'b1, 32'h1111_1111);
    chk("d32_out", FETCH_REG_OUT, 32'h1111_1111);
    chk("d32_pc", FETCH_REG_PC, 32'h0);
    chk("d32_pc4", FETCH_REG_PC_4, 32'h4);
    chk("d32_valid", {31'b0, FETCH_VALID}, 32'd1);
    chk("d32_next", bus.IMEM_ADDR, 32'h4);

    // response under stall goes to skid buffer
    step(2'd0, 1'b0, 1'b0, '0);
    step(2'd0, 1'b1, 1'b1, 32'h2222_2222);
    chk("d33_hold_pc", FETCH_REG_PC, 32'h0);
    step(2'd0, 1'b0, 1'b0, '0);
    chk("d33_pc", FETCH_REG_PC, 32'h4);
    chk("d33_out", FETCH_REG_OUT, 32'h2222_2222);
    chk("d33_next", bus.IMEM_ADDR, 32'h8);

    // JAL while waiting, late response dropped
    step(2'd0, 1'b0, 1'b0, '0);
    MUX_JAL = 32'h0000_0103;
    step(2'd3, 1'b0, 1'b0, '0);
    step(2'd0, 1'b0, 1'b0, '0);
    step(2'd0, 1'b0, 1'b1, 32'h3333_3333);
    chk("d34_valid", {31'b0, FETCH_VALID}, 32'd0);
    chk("d34_next", bus.IMEM_ADDR, 32'h100);

    // branch coincident with response and stall
    step(2'd0, 1'b0, 1'b0, '0);
    MUX_BRANCH = 32'h0000_0040;
    step(2'd2, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("d35_out", FETCH_REG_OUT, NOP);
    chk("d35_valid", {31'b0, FETCH_VALID}, 32'd0);
    chk("d35_next", bus.IMEM_ADDR, 32'h40);

    // JALR to top of address space, PC+4 wraps
    MUX_JALR = 32'hFFFF_FFFF;
    step(2'd1, 1'b0, 1'b0, '0);
    step(2'd0, 1'b0, 1'b0, '0);
    step(2'd0, 1'b0, 1'b1, 32'h4444_4444);
    chk("d36_pc", FETCH_REG_PC, 32'hFFFF_FFFC);
    chk("d36_pc4", FETCH_REG_PC_4, 32'h0);
    chk("d36_next", bus.IMEM_ADDR, 32'h0);

    // reset while waiting; stray response after release ignored
    step(2'd0, 1'b0, 1'b0, '0);
    RST = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    m_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    step(2'd0, 1'b0, 1'b1, 32'h5555_5555);
    chk("d37_valid", {31'b0, FETCH_VALID}, 32'd0);
    chk("d37_addr", bus.IMEM_ADDR, 32'h0);
    step(2'd0, 1'b0, 1'b1, 32'h6666_6666);
    chk("d37_out", FETCH_REG_OUT, 32'h6666_6666);
    chk("d37_pc", FETCH_REG_PC, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r_src = ($urandom_range(0, 99) < 6)
              ? 2'($urandom_range(1, 3)) : 2'd0;
      r_st = ($urandom_range(0, 99) < 30);
      MUX_JALR = $urandom;
      MUX_BRANCH = $urandom;
      MUX_JAL = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      r_vld = mem_busy && mem_cnt == 0;
      step(r_src, r_st, r_vld, hash(mem_addr));
      if (r_vld) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (g_req) begin
        mem_busy = 1;
        mem_addr = g_addr;
        mem_cnt = $urandom_range(0, 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 CLK  input  1  pipeline clock; all state SHALL update on its rising edge.
REQ-002 RST  input  1  reset, asynchronous, active-low; RST=0 SHALL clear all state immediately.
REQ-003 PC_SOURCE  input  2  PC select from execute: 0=PC+4, 1=JALR, 2=BRANCH, 3=JAL; nonzero means redirect.
REQ-004 MUX_JALR, MUX_BRANCH, MUX_JAL  input  32 each  redirect targets.
REQ-005 STALL  input  1  decode not ready; the IF/ID register holds.
REQ-006 IMEM_REQ  output  1  instruction-memory read request, a one-cycle pulse.
REQ-007 IMEM_ADDR  output  32  fetch address, valid with IMEM_REQ and held until IMEM_VALID.
REQ-008 IMEM_RDATA  input  32  instruction word, sampled only when IMEM_VALID=1.
REQ-009 IMEM_VALID  input  1  read response, arriving 1 or more cycles after IMEM_REQ.
REQ-010 FETCH_REG_OUT, FETCH_REG_PC, FETCH_REG_PC_4  output  32 each  IF/ID register: instruction, its PC, and PC+4.
REQ-011 FETCH_VALID  output  1  IF/ID register holds a real instruction.

Function
REQ-012 The block SHALL have states REQ (issue), WAIT (one request outstanding) and HOLD (response buffered while stalled).
REQ-013 IMEM_REQ SHALL equal (state==REQ) AND (PC_SOURCE==0), and IMEM_ADDR SHALL equal PC.
REQ-014 Transitions: REQ->WAIT when IMEM_REQ=1; WAIT->REQ on IMEM_VALID with STALL=0; WAIT->HOLD on IMEM_VALID with STALL=1; HOLD->REQ when STALL=0.
REQ-015 Accepted response in WAIT with STALL=0: load IMEM_RDATA/PC/PC+4 into IF/ID, set FETCH_VALID=1, set PC<=PC+4.
REQ-016 Response in WAIT with STALL=1: capture into a one-entry skid buffer and advance PC<=PC+4; IF/ID SHALL hold.
REQ-017 HOLD with STALL=0: load the skid buffer into IF/ID with FETCH_VALID=1, and issue the next request in the following cycle.
REQ-018 STALL=1 SHALL hold all IF/ID outputs and FETCH_VALID unchanged.
REQ-019 With STALL=0 and no instruction loaded that cycle, the block SHALL insert a bubble: FETCH_VALID<=0 and FETCH_REG_OUT<=0x00000013.
REQ-020 Redirect (PC_SOURCE!=0) SHALL have priority over STALL and any response.
REQ-021 On redirect, PC SHALL load the selected target with bits [1:0] forced to 00.
REQ-022 On redirect, the IF/ID register SHALL be bubbled as in REQ-019 and the skid buffer cleared.
REQ-023 Redirect in REQ: no request is issued that cycle; the state stays REQ at the new PC.
REQ-024 Redirect in WAIT without IMEM_VALID: set a drop flag and stay in WAIT; the next IMEM_VALID SHALL be discarded (PC unchanged) and the state goes to REQ.
REQ-025 Redirect in the same cycle as IMEM_VALID: the response SHALL be discarded and the state goes to REQ at the target.
REQ-026 Redirect in HOLD: the state SHALL go to REQ at the target.
REQ-027 PC+4 SHALL be computed mod 2^32: 0xFFFFFFFC+4 = 0x00000000.
REQ-028 Throughput with 1-cycle memory latency and no stall SHALL be one instruction per 2 cycles; at most one request is outstanding.

Reset
REQ-029 While RST=0, outputs SHALL be: PC=0x00000000, state=REQ, FETCH_VALID=0, FETCH_REG_OUT=0x00000013, FETCH_REG_PC=0, FETCH_REG_PC_4=0, IMEM_REQ=0, drop flag=0, skid buffer empty.
REQ-030 Reset asserted mid-request SHALL abandon the request, and any IMEM_VALID in the first cycle after release SHALL be ignored.
REQ-031 The first IMEM_REQ SHALL occur in the first clock edge after RST goes high, with IMEM_ADDR=0x00000000.

Verification
REQ-032 Reset release, memory returns 0x11111111 after 1 cycle -> IF/ID=(0x11111111, PC 0x0, PC_4 0x4), FETCH_VALID=1, next IMEM_ADDR=0x4.
REQ-033 STALL=1 while the response for 0x4 arrives -> IF/ID holds PC 0x0; STALL=0 -> IF/ID shows PC 0x4, then IMEM_ADDR=0x8.
REQ-034 PC_SOURCE=3 with MUX_JAL=0x103 during WAIT, 3-cycle latency -> late response dropped, FETCH_VALID=0, next IMEM_ADDR=0x100.
REQ-035 PC_SOURCE=2 with MUX_BRANCH=0x40 in the same cycle as IMEM_VALID with STALL=1 -> response discarded, IF/ID bubbled (0x00000013), IMEM_ADDR=0x40.
REQ-036 JALR to 0xFFFFFFFC, instruction returned -> FETCH_REG_PC_4=0x00000000, next IMEM_ADDR=0x00000000.
REQ-037 RST=0 asserted in WAIT, then IMEM_VALID in the first cycle after release -> response ignored, first IMEM_ADDR=0x00000000.
